// File: rtl/mv_pattern_gen.sv
// mv_pattern_gen: moving test-pattern generator for the HDMI output path.
// Takes timing hs/vs/de plus x/y and produces sync and RGB delayed by 2 cycles.
// Patterns: 0 ramp, 1 colour bars, 2 checker, 3 flash; scroll config is
// captured on each frame event (falling edge of timing_vs).
// Optional macro PATTERN_BORDER_EN forces the outermost active pixels to white.
module mv_pattern_gen #(
    parameter int unsigned DW      = 8,
    parameter int unsigned CW      = 12,
    parameter int unsigned SQ_LOG2 = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [1:0]    mode,
    input  logic [7:0]    speed,
    input  logic          dir,
    input  logic [DW-1:0] step,
    input  logic [15:0]   hactive,
    input  logic [15:0]   vactive,
    input  logic          timing_hs,
    input  logic          timing_vs,
    input  logic          timing_de,
    input  logic [CW-1:0] timing_x,
    input  logic [CW-1:0] timing_y,
    output logic          hs,
    output logic          vs,
    output logic          de,
    output logic [DW-1:0] rgb_r,
    output logic [DW-1:0] rgb_g,
    output logic [DW-1:0] rgb_b,
    output logic          frame_pulse
);

    localparam int unsigned BW = 13;

    logic          vs_in_q;
    logic          frame_evt_c;
    logic          frame_pulse_q;
    logic [1:0]    mode_s_q;
    logic [7:0]    speed_s_q;
    logic          dir_s_q;
    logic [DW-1:0] step_s_q;
    logic [7:0]    presc_q, presc_d;
    logic [DW-1:0] offset_q, offset_d;
    logic [BW-1:0] bar_w_c;
    logic [BW-1:0] bar_cnt_q, bar_cnt_d;
    logic [2:0]    bar_idx_q, bar_idx_d;
    logic [DW-1:0] ramp_c;
    logic [CW-1:0] xo_c;
    logic          chk_c;
    logic [2:0]    bar_c;
    logic          hs1_q, vs1_q, de1_q;
    logic [1:0]    mode1_q;
    logic [DW-1:0] ramp1_q;
    logic          chk1_q;
    logic [2:0]    bar1_q;
    logic [DW-1:0] flash1_q;
    logic          hs2_q, vs2_q, de2_q;
    logic [DW-1:0] r2_q, g2_q, b2_q;
    logic [DW-1:0] r_c, g_c, b_c;

    assign frame_evt_c = vs_in_q & ~timing_vs;

    // Frame detection, shadow config, prescaler and scroll offset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vs_in_q       <= 1'b0;
            frame_pulse_q <= 1'b0;
            mode_s_q      <= '0;
            speed_s_q     <= '0;
            dir_s_q       <= 1'b0;
            step_s_q      <= '0;
            presc_q       <= '0;
            offset_q      <= '0;
        end else begin
            vs_in_q       <= timing_vs;
            frame_pulse_q <= frame_evt_c;
            presc_q       <= presc_d;
            offset_q      <= offset_d;
            if (frame_evt_c) begin
                mode_s_q  <= mode;
                speed_s_q <= speed;
                dir_s_q   <= dir;
                step_s_q  <= step;
            end
        end
    end

    // Prescaler step uses the shadow values held before this event's update
    always_comb begin
        presc_d  = presc_q;
        offset_d = offset_q;
        if (frame_evt_c) begin
            if (speed_s_q == 8'd0) begin
                presc_d = '0;
            end else if (presc_q == speed_s_q - 8'd1) begin
                presc_d  = '0;
                offset_d = dir_s_q ? offset_q - step_s_q : offset_q + step_s_q;
            end else begin
                presc_d = presc_q + 8'd1;
            end
        end
    end

    assign bar_w_c = (hactive[15:3] == 13'd0) ? 13'd1 : hactive[15:3];

    // Colour-bar pixel counter and saturating bar index, cleared outside de
    always_comb begin
        bar_cnt_d = bar_cnt_q;
        bar_idx_d = bar_idx_q;
        if (!timing_de) begin
            bar_cnt_d = '0;
            bar_idx_d = '0;
        end else if (bar_cnt_q == bar_w_c - 13'd1) begin
            bar_cnt_d = '0;
            bar_idx_d = (bar_idx_q == 3'd7) ? 3'd7 : bar_idx_q + 3'd1;
        end else begin
            bar_cnt_d = bar_cnt_q + 13'd1;
        end
    end

    // Bar counter state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bar_cnt_q <= '0;
            bar_idx_q <= '0;
        end else begin
            bar_cnt_q <= bar_cnt_d;
            bar_idx_q <= bar_idx_d;
        end
    end

    assign ramp_c = timing_x[DW-1:0] + timing_y[DW-1:0] + offset_q;
    assign xo_c   = timing_x + CW'(offset_q);
    assign chk_c  = xo_c[SQ_LOG2] ^ timing_y[SQ_LOG2];
    assign bar_c  = bar_idx_q + offset_q[2:0];

`ifdef PATTERN_BORDER_EN
    logic [CW-1:0] x1_q, y1_q;
    logic          border_c;

    // Stage-1 coordinates kept for the border test in stage 2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x1_q <= '0;
            y1_q <= '0;
        end else begin
            x1_q <= timing_x;
            y1_q <= timing_y;
        end
    end

    assign border_c = (16'(x1_q) == 16'd0) || (16'(x1_q) == hactive - 16'd1) ||
                      (16'(y1_q) == 16'd0) || (16'(y1_q) == vactive - 16'd1);
`else
    logic unused_c;
    assign unused_c = ^{vactive, hactive[2:0], timing_y};
`endif

    // Stage 1: timing and per-pattern intermediates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs1_q    <= 1'b0;
            vs1_q    <= 1'b0;
            de1_q    <= 1'b0;
            mode1_q  <= '0;
            ramp1_q  <= '0;
            chk1_q   <= 1'b0;
            bar1_q   <= '0;
            flash1_q <= '0;
        end else begin
            hs1_q    <= timing_hs;
            vs1_q    <= timing_vs;
            de1_q    <= timing_de;
            mode1_q  <= mode_s_q;
            ramp1_q  <= ramp_c;
            chk1_q   <= chk_c;
            bar1_q   <= bar_c;
            flash1_q <= offset_q;
        end
    end

    // Pattern select; bar colours white..black map to inverted index bits
    always_comb begin
        r_c = '0;
        g_c = '0;
        b_c = '0;
        case (mode1_q)
            2'd0: begin
                r_c = ramp1_q;
                g_c = ramp1_q;
                b_c = ramp1_q;
            end
            2'd1: begin
                r_c = {DW{~bar1_q[1]}};
                g_c = {DW{~bar1_q[2]}};
                b_c = {DW{~bar1_q[0]}};
            end
            2'd2: begin
                r_c = {DW{chk1_q}};
                g_c = {DW{chk1_q}};
                b_c = {DW{chk1_q}};
            end
            default: begin
                r_c = flash1_q;
                g_c = flash1_q;
                b_c = flash1_q;
            end
        endcase
`ifdef PATTERN_BORDER_EN
        if (border_c) begin
            r_c = '1;
            g_c = '1;
            b_c = '1;
        end
`endif
        if (!de1_q) begin
            r_c = '0;
            g_c = '0;
            b_c = '0;
        end
    end

    // Stage 2: output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hs2_q <= 1'b0;
            vs2_q <= 1'b0;
            de2_q <= 1'b0;
            r2_q  <= '0;
            g2_q  <= '0;
            b2_q  <= '0;
        end else begin
            hs2_q <= hs1_q;
            vs2_q <= vs1_q;
            de2_q <= de1_q;
            r2_q  <= r_c;
            g2_q  <= g_c;
            b2_q  <= b_c;
        end
    end

    assign hs          = hs2_q;
    assign vs          = vs2_q;
    assign de          = de2_q;
    assign rgb_r       = r2_q;
    assign rgb_g       = g2_q;
    assign rgb_b       = b2_q;
    assign frame_pulse = frame_pulse_q;

endmodule

// File: tb/tb_mv_pattern_gen.sv
// Directed bench for mv_pattern_gen (DW=8, CW=12, SQ_LOG2=5).
module tb_mv_pattern_gen;

    localparam int unsigned DW   = 8;
    localparam int unsigned CW   = 12;
    localparam int          HACT = 64;
    localparam int          VACT = 48;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [1:0]    mode;
    logic [7:0]    speed;
    logic          dir;
    logic [DW-1:0] step;
    logic [15:0]   hactive;
    logic [15:0]   vactive;
    logic          timing_hs, timing_vs, timing_de;
    logic [CW-1:0] timing_x, timing_y;
    logic          hs, vs, de, frame_pulse;
    logic [DW-1:0] rgb_r, rgb_g, rgb_b;

    int checks = 0;
    int errors = 0;

    typedef struct {
        bit         rst;
        logic [1:0] mode;
        logic [7:0] speed;
        logic       dir;
        logic [7:0] step;
        int         nfr;
        int         x;
        int         y;
        logic [7:0] ev;
    } vec_t;

    vec_t        vecs[17];
    logic [23:0] colour_tab[8];

    mv_pattern_gen #(.DW(DW), .CW(CW), .SQ_LOG2(5)) dut (
        .clk(clk), .rst_n(rst_n), .mode(mode), .speed(speed), .dir(dir),
        .step(step), .hactive(hactive), .vactive(vactive),
        .timing_hs(timing_hs), .timing_vs(timing_vs), .timing_de(timing_de),
        .timing_x(timing_x), .timing_y(timing_y),
        .hs(hs), .vs(vs), .de(de), .rgb_r(rgb_r), .rgb_g(rgb_g), .rgb_b(rgb_b),
        .frame_pulse(frame_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic h, input logic v, input logic d, input int x, input int y);
        timing_hs = h;
        timing_vs = v;
        timing_de = d;
        timing_x  = CW'(x);
        timing_y  = CW'(y);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
    endtask

    task automatic do_frame();
        drive(0, 1, 0, 0, 0);
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check("frame_pulse_hi", 64'(frame_pulse), 64'(1));
        drive(0, 0, 0, 0, 0);
        check("frame_pulse_lo", 64'(frame_pulse), 64'(0));
    endtask

    function automatic logic [23:0] border(input int x, input int y, input logic [23:0] e);
        logic [23:0] r;
        r = e;
`ifdef PATTERN_BORDER_EN
        if (x == 0 || y == 0 || x == HACT - 1 || y == VACT - 1) r = 24'hFFFFFF;
`endif
        return r;
    endfunction

    task automatic chk_pix(input string name, input int x, input int y, input logic [23:0] e);
        logic [23:0] ex;
        ex = border(x, y, e);
        drive(0, 0, 1, x, y);
        drive(0, 0, 0, 0, 0);
        check(name, 64'({de, rgb_r, rgb_g, rgb_b}), 64'({1'b1, ex}));
    endtask

    task automatic bar_line(input int off);
        logic [23:0] ex;
        for (int i = 0; i <= HACT; i++) begin
            drive(0, 0, (i < HACT), i, 10);
            if (i >= 1) begin
                ex = border(i - 1, 10, colour_tab[((i - 1) / 8 + off) % 8]);
                check($sformatf("bar_off%0d_x%0d", off, i - 1),
                      64'({de, rgb_r, rgb_g, rgb_b}), 64'({1'b1, ex}));
            end
        end
        drive(0, 0, 0, 0, 0);
    endtask

    initial begin
        colour_tab[0] = 24'hFFFFFF; colour_tab[1] = 24'hFFFF00;
        colour_tab[2] = 24'h00FFFF; colour_tab[3] = 24'h00FF00;
        colour_tab[4] = 24'hFF00FF; colour_tab[5] = 24'hFF0000;
        colour_tab[6] = 24'h0000FF; colour_tab[7] = 24'h000000;

        //           rst mode spd dir step nfr  x     y   exp
        vecs[0]  = '{1, 2'd0, 0, 0, 0, 1,    3,  2,   8'd5};
        vecs[1]  = '{0, 2'd0, 0, 0, 0, 1,    3,  2,   8'd5};
        vecs[2]  = '{0, 2'd0, 0, 0, 0, 2,    3,  2,   8'd5};
        vecs[3]  = '{0, 2'd0, 2, 0, 4, 1,    0,  0,   8'd0};
        vecs[4]  = '{0, 2'd0, 2, 0, 4, 1,    0,  0,   8'd0};
        vecs[5]  = '{0, 2'd0, 2, 0, 4, 1,    0,  0,   8'd4};
        vecs[6]  = '{0, 2'd0, 2, 0, 4, 1,    0,  0,   8'd4};
        vecs[7]  = '{0, 2'd0, 2, 0, 4, 1,    0,  0,   8'd8};
        vecs[8]  = '{0, 2'd0, 2, 0, 4, 0,    3,  2,   8'd13};
        vecs[9]  = '{1, 2'd0, 1, 1, 1, 1,    0,  0,   8'd0};
        vecs[10] = '{0, 2'd0, 1, 1, 1, 1,    0,  0,   8'd255};
        vecs[11] = '{0, 2'd0, 1, 1, 1, 1,    2,  1,   8'd1};
        vecs[12] = '{0, 2'd3, 1, 1, 1, 1,   10, 10,   8'd253};
        vecs[13] = '{0, 2'd3, 0, 1, 1, 1,   10, 10,   8'd252};
        vecs[14] = '{0, 2'd3, 0, 1, 1, 1,   10, 10,   8'd252};
        vecs[15] = '{0, 2'd2, 0, 1, 1, 1,    1, 40,   8'd0};
        vecs[16] = '{0, 2'd2, 0, 1, 1, 0, 4090, 40,   8'd0};

        hactive = 16'(HACT);
        vactive = 16'(VACT);
        mode = 0; speed = 0; dir = 0; step = 0;
        timing_hs = 0; timing_vs = 0; timing_de = 0; timing_x = 0; timing_y = 0;
        rst_n = 1'b0;
        #12;
        check("reset_outputs", 64'({hs, vs, de, rgb_r, rgb_g, rgb_b, frame_pulse}), 64'(0));
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);

        // Sync latency: exactly two cycles
        drive(1, 0, 0, 0, 0);
        check("hs_lag1", 64'(hs), 64'(0));
        drive(0, 0, 0, 0, 0);
        check("hs_lag2", 64'(hs), 64'(1));
        drive(0, 0, 0, 0, 0);
        check("hs_lag3", 64'(hs), 64'(0));

        for (int i = 0; i < 17; i++) begin
            if (vecs[i].rst) do_reset();
            mode  = vecs[i].mode;
            speed = vecs[i].speed;
            dir   = vecs[i].dir;
            step  = vecs[i].step;
            repeat (vecs[i].nfr) do_frame();
            chk_pix($sformatf("vec%0d", i), vecs[i].x, vecs[i].y,
                    {vecs[i].ev, vecs[i].ev, vecs[i].ev});
        end

        // Colour bars at offset 0, then offset 1
        do_reset();
        mode = 1; speed = 0; dir = 0; step = 0;
        do_frame();
        bar_line(0);
        speed = 1; step = 1;
        do_frame();
        speed = 0;
        do_frame();
        bar_line(1);

        // Mid-frame mode change takes effect only at the frame event
        do_reset();
        mode = 0; speed = 0; step = 0;
        do_frame();
        chk_pix("mc_ramp_before", 32, 5, 24'h252525);
        mode = 2;
        chk_pix("mc_ramp_held", 32, 5, 24'h252525);
        chk_pix("mc_ramp_held2", 32, 32, 24'h404040);
        do_frame();
        chk_pix("mc_chk_white", 32, 0, 24'hFFFFFF);
        chk_pix("mc_chk_black", 32, 32, 24'h000000);

        // Flash at offset 0 with border override
        do_reset();
        mode = 3;
        do_frame();
        chk_pix("flash_edge", 0, 10, 24'h000000);
        chk_pix("flash_inner", 10, 10, 24'h000000);

        // Reset mid-frame drops outputs, resumes with ramp at offset 0
        mode = 0;
        do_frame();
        timing_de = 1; timing_x = 3; timing_y = 2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("pre_rst_pix", 64'({de, rgb_r, rgb_g, rgb_b}), 64'({1'b1, 24'h050505}));
        mode = 3;
        do_frame();
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", 64'({hs, vs, de, rgb_r, rgb_g, rgb_b, frame_pulse}), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        drive(0, 0, 0, 0, 0);
        chk_pix("post_rst_ramp", 3, 2, 24'h050505);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mv_pattern_gen.md
Name: mv_pattern_gen

Overview:
- Parametrised moving test-pattern generator for the HDMI output path.
- Sits between the video timing generator and the output encoder. Takes hs/vs/de plus x/y coordinates and produces delayed sync and RGB.
- Successor to the single gray-ramp mover. Adds configurable colour width, four selectable patterns, programmable scroll speed, scroll direction and step, and frame-synchronous register updates.

Parameters:
- DW, 8, colour component width; valid range 4..CW.
- CW, 12, width of timing_x/timing_y.
- SQ_LOG2, 5, checkerboard cell size = 2^SQ_LOG2 pixels.

Ports:
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- mode  in  2  pattern select: 0 ramp, 1 colour bars, 2 checker, 3 flash.
- speed  in  8  frames per scroll step; 0 = frozen.
- dir  in  1  0 = offset increments, 1 = offset decrements.
- step  in  DW  offset change per scroll step.
- hactive  in  16  active width in pixels.
- vactive  in  16  active height in lines.
- timing_hs / timing_vs / timing_de  in  1  input sync and data-enable.
- timing_x / timing_y  in  CW  active pixel coordinates.
- hs / vs / de  out  1  timing inputs delayed by 2 cycles.
- rgb_r / rgb_g / rgb_b  out  DW  pixel colour, aligned with de.
- frame_pulse  out  1  one-cycle pulse on each frame event.

Behaviour:
- Reset (async, rst_n low): all outputs 0; offset 0; prescaler 0; shadow config 0 (mode 0, speed 0, dir 0, step 0).
- Frame event: timing_vs was 1 on the previous cycle and is 0 now, using one registered copy of timing_vs. frame_pulse is asserted the cycle after the event is detected.
- Shadow config: mode, speed, dir and step are sampled only on a frame event. Input changes mid-frame have no effect until the next event.
- Prescaler (evaluated on each frame event, using the shadow values valid before the update):
  - If speed_s == 0: prescaler held at 0, offset holds.
  - Else if prescaler == speed_s-1: prescaler <= 0 and offset <= offset ± step_s, mod 2^DW.
  - Else: prescaler + 1.
- Pipeline:
  - Stage 1 registers de, x, y and the pattern intermediates.
  - Stage 2 registers rgb.
  - hs/vs/de are delayed by exactly 2 cycles. Output latency is 2 cycles for all signals.
- If the stage-2 de is 0, rgb = 0.
- Mode 0 (ramp): v = x[DW-1:0] + y[DW-1:0] + offset, mod 2^DW; r = g = b = v.
- Mode 1 (colour bars):
  - Bar width W = hactive[15:3], forced to 1 if it is 0.
  - A pixel counter and a 3-bit bar index advance during de and reset when de is low. The index increments when the counter reaches W-1, saturating at 7.
  - Displayed bar = (index + offset[2:0]) mod 8.
  - Colour order, 0..7: white, yellow, cyan, green, magenta, red, blue, black. Components are all-ones or 0.
- Mode 2 (checker): c = ((x + offset) >> SQ_LOG2)[0] XOR (y >> SQ_LOG2)[0]. c = 1 gives white (all ones), c = 0 gives black.
- Mode 3 (flash): r = g = b = offset.
- Coordinate wrap: x + offset is computed in CW bits and wraps naturally.
- Reset mid-frame: outputs drop to 0 immediately. Normal output resumes on the first de after release, using mode 0 with offset 0.

Optional Feature:
- Macro PATTERN_BORDER_EN.
- When defined: in stage 2, pixels with x == 0, x == hactive-1, y == 0 or y == vactive-1 (and de = 1) are forced to white, overriding every mode.
- When not defined: no border logic; vactive is unused.

Test Plan:
- Reset then mode 0, speed 0, 4 frames: pixel (x=3, y=2) gives r = g = b = 5 every frame; outputs lag inputs by exactly 2 cycles.
- Mode 0, speed 2, step 4, dir 0: offset sequence 0, 0, 4, 4, 8 over successive frames; at x=0, y=0 the output equals offset.
- dir 1, step 1, speed 1, from offset 0: next frame offset = 255 (DW = 8), so ramp pixel (0,0) = 255.
- Mode 1, hactive 64, offset 0: x = 0..7 white, x = 8..15 yellow (255, 255, 0), x = 56..63 black. After offset[2:0] = 1, x = 0..7 is yellow.
- Mode change from 0 to 2 mid-frame: output stays ramp until the frame event, then checker, with (32,0) = white and (32,32) = black.
- PATTERN_BORDER_EN defined, mode 3, offset 0: (0,10) = white, (10,10) = black; with the macro undefined, (0,10) = black.
